reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 191 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order results.
// 16 entries, 4-bit tags, two CDB write ports, two operand queries.
module reorder_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        issue_valid,
  input  logic [1:0]  issue_type,
  input  logic [4:0]  issue_rd,
  output logic        rob_full,
  output logic [3:0]  issue_rob_pos,
  input  logic        cdb_rs_valid,
  input  logic [3:0]  cdb_rs_rob_pos,
  input  logic [31:0] cdb_rs_val,
  input  logic        cdb_rs_mispred,
  input  logic [31:0] cdb_rs_target,
  input  logic        cdb_lsb_valid,
  input  logic [3:0]  cdb_lsb_rob_pos,
  input  logic [31:0] cdb_lsb_val,
  input  logic [3:0]  qry1_pos,
  input  logic [3:0]  qry2_pos,
  output logic        qry1_ready,
  output logic        qry2_ready,
  output logic [31:0] qry1_val,
  output logic [31:0] qry2_val,
  output logic        commit_valid,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_val,
  output logic [3:0]  commit_rob_pos,
  output logic        commit_store,
  output logic        flush,
  output logic [31:0] flush_pc
);

  localparam logic [1:0] T_BR = 2'd1;
  localparam logic [1:0] T_ST = 2'd2;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        mispred;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] target;
  } ent_t;

  ent_t        ent_q [DEPTH];
  ent_t        ent_d [DEPTH];
  logic [3:0]  head_q, head_d, tail_q, tail_d;
  logic [4:0]  count_q, count_d;
  logic        cv_q, cv_d, cs_q, cs_d, fl_q, fl_d;
  logic [4:0]  crd_q, crd_d;
  logic [31:0] cval_q, cval_d, fpc_q, fpc_d;
  logic [3:0]  cpos_q, cpos_d;
  logic        commit_fire, do_flush, issue_fire;
  ent_t        hd;

  assign rob_full      = (count_q == 5'(DEPTH));
  assign issue_rob_pos = tail_q;
  assign hd            = ent_q[head_q];
  assign commit_fire   = rdy && (count_q != 5'd0) && hd.busy && hd.ready;
  assign do_flush      = commit_fire && (hd.typ == T_BR) && hd.mispred;
  assign issue_fire    = issue_valid && !rob_full && rdy && !do_flush;

  // Next-state: CDB writes, issue, retire and mispredict recovery
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cv_d    = 1'b0;
    cs_d    = 1'b0;
    fl_d    = 1'b0;
    crd_d   = '0;
    cval_d  = '0;
    cpos_d  = '0;
    fpc_d   = '0;
    if (rdy) begin
      if (cdb_lsb_valid && ent_q[cdb_lsb_rob_pos].busy) begin
        ent_d[cdb_lsb_rob_pos].ready = 1'b1;
        ent_d[cdb_lsb_rob_pos].val   = cdb_lsb_val;
      end
      if (cdb_rs_valid && ent_q[cdb_rs_rob_pos].busy) begin
        ent_d[cdb_rs_rob_pos].ready   = 1'b1;
        ent_d[cdb_rs_rob_pos].val     = cdb_rs_val;
        ent_d[cdb_rs_rob_pos].mispred = cdb_rs_mispred;
        ent_d[cdb_rs_rob_pos].target  = cdb_rs_target;
      end
      if (issue_fire) begin
        ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, mispred: 1'b0,
                          typ: issue_type, rd: issue_rd,
                          val: 32'd0, target: 32'd0};
        tail_d = tail_q + 4'd1;
      end
      if (commit_fire) begin
        ent_d[head_q].busy  = 1'b0;
        ent_d[head_q].ready = 1'b0;
        head_d = head_q + 4'd1;
        cpos_d = head_q;
        crd_d  = hd.rd;
        cval_d = hd.val;
        cs_d   = (hd.typ == T_ST);
        cv_d   = (hd.typ != T_ST) && (hd.rd != 5'd0);
      end
      count_d = count_q + {4'd0, issue_fire} - {4'd0, commit_fire};
      if (do_flush) begin
        fl_d  = 1'b1;
        fpc_d = hd.target;
        for (int i = 0; i < DEPTH; i++) begin
          ent_d[i].busy    = 1'b0;
          ent_d[i].ready   = 1'b0;
          ent_d[i].mispred = 1'b0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  // State and registered commit/flush pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      cs_q    <= 1'b0;
      fl_q    <= 1'b0;
      crd_q   <= '0;
      cval_q  <= '0;
      cpos_q  <= '0;
      fpc_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      cs_q    <= cs_d;
      fl_q    <= fl_d;
      crd_q   <= crd_d;
      cval_q  <= cval_d;
      cpos_q  <= cpos_d;
      fpc_q   <= fpc_d;
    end
  end

  assign commit_valid   = cv_q;
  assign commit_store   = cs_q;
  assign commit_rd      = crd_q;
  assign commit_val     = cval_q;
  assign commit_rob_pos = cpos_q;
  assign flush          = fl_q;
  assign flush_pc       = fpc_q;

  logic [3:0]  qpos [2];
  logic        qrdy [2];
  logic [31:0] qval [2];

  assign qpos[0] = qry1_pos;
  assign qpos[1] = qry2_pos;

  // Operand lookup with same-cycle CDB bypass, RS ahead of LSB
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      qrdy[q] = 1'b0;
      qval[q] = '0;
      if (ent_q[qpos[q]].ready) begin
        qrdy[q] = 1'b1;
        qval[q] = ent_q[qpos[q]].val;
      end else if (cdb_rs_valid && cdb_rs_rob_pos == qpos[q]) begin
        qrdy[q] = 1'b1;
        qval[q] = cdb_rs_val;
      end else if (cdb_lsb_valid && cdb_lsb_rob_pos == qpos[q]) begin
        qrdy[q] = 1'b1;
        qval[q] = cdb_lsb_val;
      end
    end
  end

  assign qry1_ready = qrdy[0];
  assign qry1_val   = qval[0];
  assign qry2_ready = qrdy[1];
  assign qry2_val   = qval[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer.
// Scenario tasks with inline expected values.
module tb_reorder_buffer;
  logic        clk, rst, rdy;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        rob_full;
  logic [3:0]  issue_rob_pos;
  logic        cdb_rs_valid, cdb_rs_mispred;
  logic [3:0]  cdb_rs_rob_pos;
  logic [31:0] cdb_rs_val, cdb_rs_target;
  logic        cdb_lsb_valid;
  logic [3:0]  cdb_lsb_rob_pos;
  logic [31:0] cdb_lsb_val;
  logic [3:0]  qry1_pos, qry2_pos;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_val, qry2_val;
  logic        commit_valid, commit_store, flush;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val, flush_pc;
  logic [3:0]  commit_rob_pos;

  int total = 0;
  int bad = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type),
    .issue_rd(issue_rd), .rob_full(rob_full),
    .issue_rob_pos(issue_rob_pos),
    .cdb_rs_valid(cdb_rs_valid), .cdb_rs_rob_pos(cdb_rs_rob_pos),
    .cdb_rs_val(cdb_rs_val), .cdb_rs_mispred(cdb_rs_mispred),
    .cdb_rs_target(cdb_rs_target),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_pos(cdb_lsb_rob_pos),
    .cdb_lsb_val(cdb_lsb_val),
    .qry1_pos(qry1_pos), .qry2_pos(qry2_pos),
    .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
    .qry1_val(qry1_val), .qry2_val(qry2_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_rob_pos(commit_rob_pos),
    .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issue_valid = 0; issue_type = 0; issue_rd = 0;
    cdb_rs_valid = 0; cdb_rs_rob_pos = 0; cdb_rs_val = 0;
    cdb_rs_mispred = 0; cdb_rs_target = 0;
    cdb_lsb_valid = 0; cdb_lsb_rob_pos = 0; cdb_lsb_val = 0;
    qry1_pos = 0; qry2_pos = 0;
  endtask

  task automatic do_reset();
    clr();
    rdy = 1;
    rst = 0;
    step();
    rst = 1;
  endtask

  task automatic iss(input logic [1:0] t, input logic [4:0] rd);
    issue_valid = 1; issue_type = t; issue_rd = rd;
    step();
    issue_valid = 0;
  endtask

  task automatic rs(input logic [3:0] p, input logic [31:0] v);
    cdb_rs_valid = 1; cdb_rs_rob_pos = p; cdb_rs_val = v;
  endtask

  task automatic lsb(input logic [3:0] p, input logic [31:0] v);
    cdb_lsb_valid = 1; cdb_lsb_rob_pos = p; cdb_lsb_val = v;
  endtask

  task automatic test_reset();
    clr(); rdy = 1; rst = 0;
    #2;
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rst_cv: got %0h exp 0", commit_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %0h exp 0", flush); end
    total++; if (rob_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %0h exp 0", rob_full); end
    total++; if (issue_rob_pos !== 4'd0) begin bad++; $display("FAIL rst_tail: got %0h exp 0", issue_rob_pos); end
    total++; if (dut.count_q !== 5'd0) begin bad++; $display("FAIL rst_count: got %0h exp 0", dut.count_q); end
    step();
    rst = 1;
  endtask

  task automatic test_basic();
    do_reset();
    total++; if (issue_rob_pos !== 4'd0) begin bad++; $display("FAIL basic_tag: got %0h exp 0", issue_rob_pos); end
    iss(2'd0, 5'd5);
    total++; if (dut.count_q !== 5'd1) begin bad++; $display("FAIL basic_cnt1: got %0h exp 1", dut.count_q); end
    rs(4'd0, 32'h1234);
    step();
    clr();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %0h exp 0", commit_valid); end
    step();
    total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL basic_cv: got %0h exp 1", commit_valid); end
    total++; if (commit_rd !== 5'd5) begin bad++; $display("FAIL basic_rd: got %0h exp 5", commit_rd); end
    total++; if (commit_val !== 32'h1234) begin bad++; $display("FAIL basic_val: got %0h exp 1234", commit_val); end
    total++; if (dut.count_q !== 5'd0) begin bad++; $display("FAIL basic_cnt0: got %0h exp 0", dut.count_q); end
    step();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %0h exp 0", commit_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) iss(2'd0, 5'(i + 1));
    total++; if (rob_full !== 1'b1) begin bad++; $display("FAIL full_flag: got %0h exp 1", rob_full); end
    total++; if (dut.count_q !== 5'd16) begin bad++; $display("FAIL full_cnt: got %0h exp 16", dut.count_q); end
    total++; if (issue_rob_pos !== 4'd0) begin bad++; $display("FAIL full_tail: got %0h exp 0", issue_rob_pos); end
    iss(2'd0, 5'd20);
    total++; if (dut.count_q !== 5'd16) begin bad++; $display("FAIL full_ign: got %0h exp 16", dut.count_q); end
    lsb(4'd0, 32'h55);
    step();
    clr();
    step();
    total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL full_cv: got %0h exp 1", commit_valid); end
    total++; if (commit_rd !== 5'd1) begin bad++; $display("FAIL full_rd: got %0h exp 1", commit_rd); end
    total++; if (commit_val !== 32'h55) begin bad++; $display("FAIL full_val: got %0h exp 55", commit_val); end
    total++; if (rob_full !== 1'b0) begin bad++; $display("FAIL full_free: got %0h exp 0", rob_full); end
    total++; if (issue_rob_pos !== 4'd0) begin bad++; $display("FAIL full_wrap: got %0h exp 0", issue_rob_pos); end
    iss(2'd0, 5'd21);
    total++; if (rob_full !== 1'b1) begin bad++; $display("FAIL full_again: got %0h exp 1", rob_full); end
    total++; if (issue_rob_pos !== 4'd1) begin bad++; $display("FAIL full_tail1: got %0h exp 1", issue_rob_pos); end
  endtask

  task automatic test_order();
    do_reset();
    iss(2'd0, 5'd10);
    iss(2'd0, 5'd11);
    iss(2'd0, 5'd12);
    rs(4'd2, 32'h22); step();
    rs(4'd1, 32'h11); step();
    rs(4'd0, 32'h10); step();
    clr();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL ord_none: got %0h exp 0", commit_valid); end
    step();
    total++; if (commit_rob_pos !== 4'd0 || commit_val !== 32'h10) begin bad++; $display("FAIL ord_0: got %0h/%0h exp 0/10", commit_rob_pos, commit_val); end
    step();
    total++; if (commit_rob_pos !== 4'd1 || commit_rd !== 5'd11) begin bad++; $display("FAIL ord_1: got %0h/%0h exp 1/b", commit_rob_pos, commit_rd); end
    step();
    total++; if (commit_rob_pos !== 4'd2 || commit_val !== 32'h22) begin bad++; $display("FAIL ord_2: got %0h/%0h exp 2/22", commit_rob_pos, commit_val); end
    step();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL ord_end: got %0h exp 0", commit_valid); end
  endtask

  task automatic test_types();
    do_reset();
    iss(2'd0, 5'd0);
    iss(2'd2, 5'd0);
    iss(2'd1, 5'd1);
    rs(4'd0, 32'h11); lsb(4'd1, 32'h22); step();
    clr();
    rs(4'd2, 32'h33); step();
    clr();
    total++; if (commit_valid !== 1'b0 || commit_rob_pos !== 4'd0) begin bad++; $display("FAIL typ_x0: got %0h/%0h exp 0/0", commit_valid, commit_rob_pos); end
    total++; if (dut.count_q !== 5'd2) begin bad++; $display("FAIL typ_x0cnt: got %0h exp 2", dut.count_q); end
    step();
    total++; if (commit_store !== 1'b1 || commit_valid !== 1'b0) begin bad++; $display("FAIL typ_st: got %0h/%0h exp 1/0", commit_store, commit_valid); end
    total++; if (commit_rob_pos !== 4'd1) begin bad++; $display("FAIL typ_stpos: got %0h exp 1", commit_rob_pos); end
    step();
    total++; if (commit_valid !== 1'b1 || commit_val !== 32'h33) begin bad++; $display("FAIL typ_br: got %0h/%0h exp 1/33", commit_valid, commit_val); end
    total++; if (flush !== 1'b0 || commit_store !== 1'b0) begin bad++; $display("FAIL typ_brfl: got %0h/%0h exp 0/0", flush, commit_store); end
  endtask

  task automatic test_dual();
    do_reset();
    iss(2'd0, 5'd3);
    iss(2'd0, 5'd4);
    iss(2'd0, 5'd6);
    rs(4'd0, 32'hA); lsb(4'd1, 32'hB); step();
    rs(4'd2, 32'hC); lsb(4'd2, 32'hD); step();
    clr();
    total++; if (commit_val !== 32'hA) begin bad++; $display("FAIL dual_0: got %0h exp a", commit_val); end
    step();
    total++; if (commit_val !== 32'hB) begin bad++; $display("FAIL dual_1: got %0h exp b", commit_val); end
    step();
    total++; if (commit_val !== 32'hC) begin bad++; $display("FAIL dual_same: got %0h exp c", commit_val); end
    rs(4'd5, 32'h99); step();
    clr();
    qry1_pos = 4'd5;
    #1;
    total++; if (qry1_ready !== 1'b0 || qry1_val !== 32'd0) begin bad++; $display("FAIL dual_idle: got %0h/%0h exp 0/0", qry1_ready, qry1_val); end
  endtask

  task automatic test_mispred();
    do_reset();
    iss(2'd0, 5'd2);
    iss(2'd1, 5'd1);
    iss(2'd0, 5'd3);
    iss(2'd0, 5'd4);
    rs(4'd1, 32'h44); cdb_rs_mispred = 1; cdb_rs_target = 32'h80; step();
    clr();
    rs(4'd0, 32'h10); step();
    clr();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL mp_early: got %0h exp 0", commit_valid); end
    step();
    total++; if (commit_rob_pos !== 4'd0 || flush !== 1'b0) begin bad++; $display("FAIL mp_c0: got %0h/%0h exp 0/0", commit_rob_pos, flush); end
    iss(2'd0, 5'd9);
    total++; if (flush !== 1'b1 || flush_pc !== 32'h80) begin bad++; $display("FAIL mp_flush: got %0h/%0h exp 1/80", flush, flush_pc); end
    total++; if (commit_valid !== 1'b1 || commit_val !== 32'h44) begin bad++; $display("FAIL mp_link: got %0h/%0h exp 1/44", commit_valid, commit_val); end
    total++; if (dut.count_q !== 5'd0 || issue_rob_pos !== 4'd0) begin bad++; $display("FAIL mp_clear: got %0h/%0h exp 0/0", dut.count_q, issue_rob_pos); end
    rs(4'd2, 32'h77); step();
    clr();
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL mp_pulse: got %0h exp 0", flush); end
    qry1_pos = 4'd2;
    #1;
    total++; if (qry1_ready !== 1'b0) begin bad++; $display("FAIL mp_stale: got %0h exp 0", qry1_ready); end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 4; i++) iss(2'd0, 5'(i + 1));
    qry1_pos = 4'd3; qry2_pos = 4'd2;
    lsb(4'd3, 32'hAB);
    #1;
    total++; if (qry1_ready !== 1'b1 || qry1_val !== 32'hAB) begin bad++; $display("FAIL byp_lsb: got %0h/%0h exp 1/ab", qry1_ready, qry1_val); end
    total++; if (qry2_ready !== 1'b0 || qry2_val !== 32'd0) begin bad++; $display("FAIL byp_q2: got %0h/%0h exp 0/0", qry2_ready, qry2_val); end
    rs(4'd3, 32'hCD);
    #1;
    total++; if (qry1_val !== 32'hCD) begin bad++; $display("FAIL byp_rs: got %0h exp cd", qry1_val); end
    step();
    cdb_rs_valid = 0; cdb_lsb_valid = 0;
    #1;
    total++; if (qry1_ready !== 1'b1 || qry1_val !== 32'hCD) begin bad++; $display("FAIL byp_stored: got %0h/%0h exp 1/cd", qry1_ready, qry1_val); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) iss(2'd0, 5'(i + 1));
    rs(4'd0, 32'h77); step();
    clr();
    step();
    total++; if (commit_valid !== 1'b1 || dut.count_q !== 5'd5) begin bad++; $display("FAIL mid_pre: got %0h/%0h exp 1/5", commit_valid, dut.count_q); end
    rst = 0;
    #1;
    total++; if (commit_valid !== 1'b0 || commit_rd !== 5'd0 || commit_val !== 32'd0) begin bad++; $display("FAIL mid_out: got %0h/%0h/%0h exp 0/0/0", commit_valid, commit_rd, commit_val); end
    total++; if (dut.count_q !== 5'd0 || issue_rob_pos !== 4'd0) begin bad++; $display("FAIL mid_cnt: got %0h/%0h exp 0/0", dut.count_q, issue_rob_pos); end
    #1;
    rst = 1;
    step();
    total++; if (issue_rob_pos !== 4'd0) begin bad++; $display("FAIL mid_tag: got %0h exp 0", issue_rob_pos); end
    iss(2'd0, 5'd1);
    total++; if (dut.count_q !== 5'd1) begin bad++; $display("FAIL mid_iss: got %0h exp 1", dut.count_q); end
  endtask

  task automatic test_rdy();
    do_reset();
    iss(2'd0, 5'd7);
    iss(2'd0, 5'd8);
    rdy = 0;
    rs(4'd0, 32'h5);
    issue_valid = 1; issue_rd = 5'd9;
    step(); step(); step();
    total++; if (dut.count_q !== 5'd2 || issue_rob_pos !== 4'd2) begin bad++; $display("FAIL rdy_hold: got %0h/%0h exp 2/2", dut.count_q, issue_rob_pos); end
    rdy = 1;
    clr();
    step();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rdy_nocdb: got %0h exp 0", commit_valid); end
    rs(4'd0, 32'h5); step();
    clr();
    step();
    total++; if (commit_valid !== 1'b1 || commit_rd !== 5'd7) begin bad++; $display("FAIL rdy_cv: got %0h/%0h exp 1/7", commit_valid, commit_rd); end
    rdy = 0;
    step();
    total++; if (commit_valid !== 1'b0 || dut.count_q !== 5'd1) begin bad++; $display("FAIL rdy_pulse: got %0h/%0h exp 0/1", commit_valid, dut.count_q); end
    rdy = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_order();
    test_types();
    test_dual();
    test_mispred();
    test_bypass();
    test_reset_mid();
    test_rdy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
